// File: rtl/riscv_pkg.sv
// Shared RV32I load/store encodings, MEM-stage FSM states and bus request payload.
package riscv_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned STRB_W = WORD_W / 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} mau_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] addr;
    logic              we;
    logic [STRB_W-1:0] wstrb;
    logic [WORD_W-1:0] wdata;
  } mem_req_t;

  // Byte enables for a legal store at the given byte offset.
  function automatic logic [STRB_W-1:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B:    return 4'b0001 << off;
      F3_H:    return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  // Store data replicated across every lane it could land in.
  function automatic logic [WORD_W-1:0] store_data(input logic [2:0] f3, input logic [WORD_W-1:0] d);
    case (f3)
      F3_B:    return {4{d[7:0]}};
      F3_H:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/half lane of a read word and sign- or zero-extends it.
module lsu_load_align
  import riscv_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [1:0]        byte_off,
  input  logic [WORD_W-1:0] word,
  output logic [WORD_W-1:0] data_c
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = 8'h00;
    lane_h = byte_off[1] ? word[31:16] : word[15:0];
    case (byte_off)
      2'd0: lane_b = word[7:0];
      2'd1: lane_b = word[15:8];
      2'd2: lane_b = word[23:16];
      2'd3: lane_b = word[31:24];
      default: lane_b = 8'h00;
    endcase
  end

  always_comb begin
    data_c = word;
    case (funct3)
      F3_B:    data_c = {{24{lane_b[7]}}, lane_b};
      F3_H:    data_c = {{16{lane_h[15]}}, lane_h};
      F3_BU:   data_c = {24'h000000, lane_b};
      F3_HU:   data_c = {16'h0000, lane_h};
      default: data_c = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: issues one valid/ready bus transaction per access and
// stalls the pipeline until the access completes.
module mem_access_unit
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            MemReadM,
  input  logic            MemWriteM,
  input  logic [2:0]      funct3M,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] WriteDataM,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_we,
  output logic [3:0]      mem_wstrb,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] ReadDataM,
  output logic            StallM,
  output logic            FlushW,
  output logic            MisalignM
);

  mau_state_t        state;
  mem_req_t          req_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [XLEN-1:0]   rdata_q;
  logic              mis_c;
  logic              op_c;
  logic [XLEN-1:0]   load_c;

  // Alignment and funct3 legality; a load wins when both strobes are set.
  always_comb begin
    mis_c = 1'b0;
    if (MemReadM) begin
      case (funct3M)
        F3_B, F3_BU: mis_c = 1'b0;
        F3_H, F3_HU: mis_c = ALUResultM[0];
        F3_W:        mis_c = |ALUResultM[1:0];
        default:     mis_c = 1'b1;
      endcase
    end else if (MemWriteM) begin
      case (funct3M)
        F3_B:    mis_c = 1'b0;
        F3_H:    mis_c = ALUResultM[0];
        F3_W:    mis_c = |ALUResultM[1:0];
        default: mis_c = 1'b1;
      endcase
    end
  end

  assign MisalignM = mis_c;
  assign op_c      = (MemReadM | MemWriteM) & ~mis_c;
  assign StallM    = op_c & (state != DONE);
  assign FlushW    = StallM;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      req_q         <= '0;
      mem_req_valid <= 1'b0;
      f3_q          <= 3'b000;
      off_q         <= 2'b00;
      rdata_q       <= '0;
    end else begin
      case (state)
        IDLE: if (op_c) begin
          state         <= REQ;
          mem_req_valid <= 1'b1;
          req_q.addr    <= {ALUResultM[XLEN-1:2], 2'b00};
          req_q.we      <= ~MemReadM;
          req_q.wstrb   <= MemReadM ? 4'b0000 : store_strb(funct3M, ALUResultM[1:0]);
          req_q.wdata   <= MemReadM ? '0 : store_data(funct3M, WriteDataM);
          f3_q          <= funct3M;
          off_q         <= ALUResultM[1:0];
        end
        REQ: if (mem_req_ready) begin
          mem_req_valid <= 1'b0;
          state         <= req_q.we ? DONE : RESP;
        end
        RESP: if (mem_rsp_valid) begin
          rdata_q <= mem_rdata;
          state   <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_addr  = req_q.addr;
  assign mem_we    = req_q.we;
  assign mem_wstrb = req_q.wstrb;
  assign mem_wdata = req_q.wdata;

  lsu_load_align u_align (
    .funct3   (f3_q),
    .byte_off (off_q),
    .word     (rdata_q),
    .data_c   (load_c)
  );

  assign ReadDataM = (state == DONE) ? load_c : '0;

endmodule
